// File: rtl/ringbuf_evt_reader_pkg.sv
// Shared types for the ring-buffer event reader: channel geometry, word width,
// FSM encoding and the alignment tag carried alongside each issued read.
package dcfeb_rb_pkg;

    localparam int N_CHAN = 16;
    localparam int SAMP_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        DRAIN,
        DONE
    } rd_state_t;

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } algn_t;

endpackage

// File: rtl/ringbuf_evt_reader_if.sv
// Ring-buffer read port plus readout-FIFO write stream; master = event reader.
interface ringbuf_evt_reader_if #(
    parameter int ADDR_W = 12
);
    import dcfeb_rb_pkg::*;

    logic              RB_RDEN;
    logic [ADDR_W-1:0] RB_ADDR;
    logic [SAMP_W-1:0] RB_DOUT;
    logic              OFIFO_AFULL;
    logic [SAMP_W-1:0] DOUT;
    logic              DOUT_VLD;
    logic              DOUT_FIRST;
    logic              DOUT_LAST;

    modport master (
        output RB_RDEN, RB_ADDR, DOUT, DOUT_VLD, DOUT_FIRST, DOUT_LAST,
        input  RB_DOUT, OFIFO_AFULL
    );

    modport slave (
        input  RB_RDEN, RB_ADDR, DOUT, DOUT_VLD, DOUT_FIRST, DOUT_LAST,
        output RB_DOUT, OFIFO_AFULL
    );

endinterface

// File: rtl/ringbuf_evt_reader_trig_addr_fifo.sv
// Pending-trigger address queue: synchronous FIFO that accepts a push on a full
// queue when a pop happens in the same cycle.
module trig_addr_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_cnt == CW'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_dout    = r_mem[r_rptr];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_do_push)
                r_wptr <= (r_wptr == PLAST) ? '0 : r_wptr + 1'b1;
            if (w_do_pop)
                r_rptr <= (r_rptr == PLAST) ? '0 : r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers above.
    always_ff @(posedge CLK) begin
        if (w_do_push)
            r_mem[r_wptr] <= i_din;
    end

endmodule

// File: rtl/ringbuf_evt_reader.sv
// Ring-buffer event reader: walks one event block per trigger (channel, chip,
// sample order), streams framed words to the readout FIFO and reports the freed block.
module ringbuf_evt_reader
    import dcfeb_rb_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int RB_DEPTH = 4096,
    parameter int N_CHIP   = 6,
    parameter int RB_LAT   = 2,
    parameter int QDEPTH   = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              JTAG_MODE,
    input  logic [6:0]        SAMP_MAX,
    input  logic              TRIG,
    input  logic [ADDR_W-1:0] TRIG_ADDR,
    ringbuf_evt_reader_if.master bus,
    output logic              BLK_DONE,
    output logic [ADDR_W-1:0] BLK_DONE_ADDR,
    output logic              BUSY,
    output logic              TRIG_OVF
);
    localparam int CHIP_W = (N_CHIP > 1) ? $clog2(N_CHIP) : 1;
    localparam int DRN_W  = $clog2(RB_LAT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RB_DEPTH - 1);
    localparam logic [CHIP_W-1:0] LAST_CHIP = CHIP_W'(N_CHIP - 1);
    localparam logic [3:0]        LAST_CHAN = 4'(N_CHAN - 1);

    rd_state_t         r_state;
    rd_state_t         w_next;
    logic              w_push_req;
    logic              w_pop;
    logic              w_q_full;
    logic              w_q_empty;
    logic [ADDR_W-1:0] w_q_head;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_start;
    logic [3:0]        r_chan;
    logic [CHIP_W-1:0] r_chip;
    logic [6:0]        r_samp;
    logic [6:0]        r_samp_max;
    logic [DRN_W-1:0]  r_drain;
    logic              w_issue;
    logic              w_done;
    logic              w_first_word;
    logic              w_last_word;
    algn_t             w_issue_tag;
    algn_t             w_pre_out;
    algn_t             r_algn [RB_LAT];
    logic [SAMP_W-1:0] r_dout;
    logic              r_ovf;

    assign w_push_req = TRIG & ~JTAG_MODE;

    trig_addr_fifo #(
        .W     (ADDR_W),
        .DEPTH (QDEPTH)
    ) u_trig_q (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (w_push_req),
        .i_din   (TRIG_ADDR),
        .i_pop   (w_pop),
        .o_dout  (w_q_head),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // A trigger arriving while idle starts LOAD directly, so the pop sees it next cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!JTAG_MODE && (!w_q_empty || w_push_req)) w_next = LOAD;
            LOAD:    w_next = READ;
            READ:    if (w_issue && w_last_word) w_next = DRAIN;
            DRAIN:   if (r_drain == DRN_W'(RB_LAT - 1)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_pop   = 1'b0;
        w_issue = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            LOAD:    w_pop   = 1'b1;
            READ:    w_issue = ~bus.OFIFO_AFULL;
            DONE:    w_done  = 1'b1;
            default: ;
        endcase
    end

    assign w_first_word = (r_chan == '0) && (r_chip == '0) && (r_samp == '0);
    assign w_last_word  = (r_chan == LAST_CHAN) && (r_chip == LAST_CHIP) && (r_samp == r_samp_max);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_addr     <= '0;
            r_start    <= '0;
            r_chan     <= '0;
            r_chip     <= '0;
            r_samp     <= '0;
            r_samp_max <= '0;
            r_drain    <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (r_state == LOAD) begin
                r_addr     <= w_q_head;
                r_start    <= w_q_head;
                r_chan     <= '0;
                r_chip     <= '0;
                r_samp     <= '0;
                r_samp_max <= SAMP_MAX;
            end else if (w_issue) begin
                // Wrap at the buffer depth, which need not be a power of two.
                r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
                r_chan <= (r_chan == LAST_CHAN) ? '0 : r_chan + 1'b1;
                if (r_chan == LAST_CHAN) begin
                    if (r_chip == LAST_CHIP) begin
                        r_chip <= '0;
                        r_samp <= r_samp + 1'b1;
                    end else begin
                        r_chip <= r_chip + 1'b1;
                    end
                end
            end
            r_drain <= (r_state == DRAIN) ? r_drain + 1'b1 : '0;
            r_ovf   <= r_ovf | (w_push_req & w_q_full & ~w_pop);
        end
    end

    assign w_issue_tag = '{vld: w_issue, first: w_issue & w_first_word, last: w_issue & w_last_word};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < RB_LAT; k++) r_algn[k] <= '0;
        end else begin
            r_algn[0] <= w_issue_tag;
            for (int k = 1; k < RB_LAT; k++) r_algn[k] <= r_algn[k-1];
        end
    end

    // The output data register is the final alignment stage; it captures RB_DOUT
    // in the cycle the tag sits one stage before the output.
    generate
        if (RB_LAT == 1) begin : g_pre_issue
            assign w_pre_out = w_issue_tag;
        end else begin : g_pre_pipe
            assign w_pre_out = r_algn[RB_LAT-2];
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_dout <= '0;
        else     r_dout <= w_pre_out.vld ? bus.RB_DOUT : '0;
    end

    assign bus.RB_RDEN    = w_issue;
    assign bus.RB_ADDR    = r_addr;
    assign bus.DOUT       = r_dout;
    assign bus.DOUT_VLD   = r_algn[RB_LAT-1].vld;
    assign bus.DOUT_FIRST = r_algn[RB_LAT-1].first;
    assign bus.DOUT_LAST  = r_algn[RB_LAT-1].last;
    assign BLK_DONE       = w_done;
    assign BLK_DONE_ADDR  = w_done ? r_start : '0;
    assign BUSY           = (r_state != IDLE) | ~w_q_empty;
    assign TRIG_OVF       = r_ovf;

endmodule

// File: tb/tb_ringbuf_evt_reader.sv
// Directed bench for ringbuf_evt_reader with a one-register ring-buffer model
// (RB_LAT=2) and a negedge collector of reads, output words and block-done events.
module tb_ringbuf_evt_reader;

    logic        CLK = 1'b0;
    logic        RST;
    logic        JTAG_MODE;
    logic [6:0]  SAMP_MAX;
    logic        TRIG;
    logic [11:0] TRIG_ADDR;
    logic        BLK_DONE;
    logic [11:0] BLK_DONE_ADDR;
    logic        BUSY;
    logic        TRIG_OVF;

    ringbuf_evt_reader_if #(.ADDR_W(12)) bus ();

    ringbuf_evt_reader #(
        .ADDR_W   (12),
        .RB_DEPTH (4096),
        .N_CHIP   (6),
        .RB_LAT   (2),
        .QDEPTH   (4)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .JTAG_MODE     (JTAG_MODE),
        .SAMP_MAX      (SAMP_MAX),
        .TRIG          (TRIG),
        .TRIG_ADDR     (TRIG_ADDR),
        .bus           (bus),
        .BLK_DONE      (BLK_DONE),
        .BLK_DONE_ADDR (BLK_DONE_ADDR),
        .BUSY          (BUSY),
        .TRIG_OVF      (TRIG_OVF)
    );

    localparam logic [11:0] KEY = 12'h5A3;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          trig_cyc;
    int          first_vld_cyc, first_rden_cyc, last_vld_cyc, done_cyc, viol;
    logic [11:0] wq_data[$];
    logic        wq_first[$];
    logic        wq_last[$];
    logic [11:0] aq[$];
    logic [11:0] dq[$];

    initial forever #5 CLK = ~CLK;
    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Ring buffer: registered read, content = address ^ KEY
    initial forever begin
        @(posedge CLK);
        if (bus.RB_RDEN) bus.RB_DOUT <= bus.RB_ADDR ^ KEY;
    end

    initial forever begin
        @(negedge CLK);
        if (bus.DOUT_VLD) begin
            if (wq_data.size() == 0) first_vld_cyc = cyc;
            wq_data.push_back(bus.DOUT);
            wq_first.push_back(bus.DOUT_FIRST);
            wq_last.push_back(bus.DOUT_LAST);
            if (bus.DOUT_LAST) last_vld_cyc = cyc;
        end
        if (bus.RB_RDEN) begin
            if (aq.size() == 0) first_rden_cyc = cyc;
            aq.push_back(bus.RB_ADDR);
            if (bus.OFIFO_AFULL) viol++;
        end
        if (BLK_DONE) begin
            dq.push_back(BLK_DONE_ADDR);
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        wq_data.delete();
        wq_first.delete();
        wq_last.delete();
        aq.delete();
        dq.delete();
        first_vld_cyc  = -1;
        first_rden_cyc = -1;
        last_vld_cyc   = -1;
        done_cyc       = -1;
        viol           = 0;
    endtask

    task automatic pulse_trig(input logic [11:0] a);
        @(posedge CLK); #1;
        TRIG      = 1'b1;
        TRIG_ADDR = a;
        trig_cyc  = cyc;
        @(posedge CLK); #1;
        TRIG = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n, input int budget);
        int k = 0;
        while (dq.size() < n && k < budget) begin
            @(negedge CLK);
            k++;
        end
        repeat (4) @(negedge CLK);
        chk({tag, "_ndone"}, dq.size(), n);
    endtask

    // Compares one event's reads and words against start+i mod 4096 and its framing.
    task automatic check_event(input string tag, input logic [11:0] start, input int n, input int base);
        int bad_a = 0;
        int bad_d = 0;
        int bad_f = 0;
        logic [11:0] a;
        for (int i = 0; i < n; i++) begin
            a = 12'((int'(start) + i) % 4096);
            if (base + i < aq.size()) begin
                if (aq[base+i] !== a) bad_a++;
            end else bad_a++;
            if (base + i < wq_data.size()) begin
                if (wq_data[base+i] !== (a ^ KEY)) bad_d++;
                if (wq_first[base+i] !== (i == 0)) bad_f++;
                if (wq_last[base+i] !== (i == n - 1)) bad_f++;
            end else bad_d++;
        end
        chk({tag, "_addr_err"}, bad_a, 0);
        chk({tag, "_data_err"}, bad_d, 0);
        chk({tag, "_frame_err"}, bad_f, 0);
    endtask

    initial begin
        RST = 1'b1;
        JTAG_MODE = 1'b0;
        SAMP_MAX = 7'd0;
        TRIG = 1'b0;
        TRIG_ADDR = 12'h000;
        bus.OFIFO_AFULL = 1'b0;
        clear_obs();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_rden", bus.RB_RDEN, 0);
        chk("rst_addr", bus.RB_ADDR, 0);
        chk("rst_dout", bus.DOUT, 0);
        chk("rst_vld", bus.DOUT_VLD, 0);
        chk("rst_done", BLK_DONE, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_ovf", TRIG_OVF, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (2) @(posedge CLK);

        // 1: basic 96-word event, latency and framing
        clear_obs();
        SAMP_MAX = 7'd0;
        pulse_trig(12'h010);
        wait_done("t1", 1, 500);
        chk("t1_rden_lat", first_rden_cyc, trig_cyc + 2);
        chk("t1_vld_lat", first_vld_cyc, trig_cyc + 4);
        chk("t1_nreads", aq.size(), 96);
        chk("t1_nwords", wq_data.size(), 96);
        chk("t1_last_addr", (aq.size() == 96) ? aq[95] : 12'hBAD, 12'h06F);
        check_event("t1", 12'h010, 96, 0);
        chk("t1_done_addr", (dq.size() > 0) ? dq[0] : 12'hBAD, 12'h010);
        chk("t1_done_after_last", done_cyc, last_vld_cyc + 1);
        chk("t1_busy_end", BUSY, 0);

        // 2: address wrap, two samples
        clear_obs();
        SAMP_MAX = 7'd1;
        pulse_trig(12'hFF0);
        wait_done("t2", 1, 1000);
        chk("t2_nwords", wq_data.size(), 192);
        chk("t2_addr15", (aq.size() > 16) ? aq[15] : 12'hBAD, 12'hFFF);
        chk("t2_addr16", (aq.size() > 16) ? aq[16] : 12'hBAD, 12'h000);
        check_event("t2", 12'hFF0, 192, 0);
        chk("t2_done_addr", (dq.size() > 0) ? dq[0] : 12'hBAD, 12'hFF0);

        // 3: random back-pressure
        clear_obs();
        SAMP_MAX = 7'd0;
        pulse_trig(12'h123);
        for (int k = 0; k < 2000 && dq.size() < 1; k++) begin
            @(posedge CLK); #1;
            bus.OFIFO_AFULL = 1'($urandom_range(0, 1));
        end
        bus.OFIFO_AFULL = 1'b0;
        wait_done("t3", 1, 100);
        chk("t3_rden_while_afull", viol, 0);
        chk("t3_nwords", wq_data.size(), 96);
        check_event("t3", 12'h123, 96, 0);

        // 4: six back-to-back triggers, queue depth 4
        clear_obs();
        SAMP_MAX = 7'd0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge CLK); #1;
            TRIG = 1'b1;
            TRIG_ADDR = 12'(k * 12'h100);
        end
        @(posedge CLK); #1;
        TRIG = 1'b0;
        chk("t4_ovf_set", TRIG_OVF, 1);
        wait_done("t4", 5, 5000);
        repeat (10) @(negedge CLK);
        chk("t4_ndone_final", dq.size(), 5);
        chk("t4_nwords", wq_data.size(), 480);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t4_done_addr%0d", k), (dq.size() > k) ? dq[k] : 12'hBAD, 12'((k + 1) * 12'h100));
            check_event($sformatf("t4_ev%0d", k), 12'((k + 1) * 12'h100), 96, k * 96);
        end
        chk("t4_ovf_sticky", TRIG_OVF, 1);
        chk("t4_busy_end", BUSY, 0);

        // 5: reset mid-event
        clear_obs();
        pulse_trig(12'h200);
        for (int k = 0; k < 500 && wq_data.size() < 40; k++) @(negedge CLK);
        chk("t5_words_before_rst", wq_data.size(), 40);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        chk("t5_rst_rden", bus.RB_RDEN, 0);
        chk("t5_rst_vld", bus.DOUT_VLD, 0);
        chk("t5_rst_dout", bus.DOUT, 0);
        chk("t5_rst_busy", BUSY, 0);
        chk("t5_rst_ovf", TRIG_OVF, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (10) @(negedge CLK);
        chk("t5_no_more_words", wq_data.size(), 40);
        chk("t5_no_done", dq.size(), 0);
        clear_obs();
        pulse_trig(12'h300);
        wait_done("t5b", 1, 500);
        chk("t5b_nwords", wq_data.size(), 96);
        check_event("t5b", 12'h300, 96, 0);

        // 6: JTAG mode blocks new events
        clear_obs();
        @(posedge CLK); #1;
        JTAG_MODE = 1'b1;
        pulse_trig(12'h400);
        repeat (20) @(negedge CLK);
        chk("t6_jtag_reads", aq.size(), 0);
        chk("t6_jtag_busy", BUSY, 0);
        chk("t6_jtag_ovf", TRIG_OVF, 0);
        @(posedge CLK); #1;
        JTAG_MODE = 1'b0;
        repeat (5) @(negedge CLK);
        chk("t6_ignored_trig", aq.size(), 0);
        pulse_trig(12'h410);
        wait_done("t6", 1, 500);
        check_event("t6", 12'h410, 96, 0);
        chk("t6_done_addr", (dq.size() > 0) ? dq[0] : 12'hBAD, 12'h410);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
